// File: rtl/dsel_arb_pkg.sv
// Shared types and constants for the dsel write-side arbiter.
package dsel_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_e;

  localparam int CFG_PRIO_BIT = 0;
  localparam int CFG_MODE_BIT = 2;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic logic src_of(arb_state_e s);
    return (s == GNT_B) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/dsel_wr_arbiter_if.sv
// Request channels A/B and the SRAM write port of the dsel write arbiter.
interface dsel_wr_arbiter_if #(
  parameter int LOC_AWIDTH = 32,
  parameter int LOC_DWIDTH = 32
);
  logic                  in_valid_a;
  logic                  in_ready_a;
  logic [LOC_AWIDTH-1:0] in_addr_a;
  logic [LOC_DWIDTH-1:0] in_data_a;
  logic                  in_valid_b;
  logic                  in_ready_b;
  logic [LOC_AWIDTH-1:0] in_addr_b;
  logic [LOC_DWIDTH-1:0] in_data_b;
  logic                  ram_wr_en;
  logic [LOC_AWIDTH-1:0] ram_wr_addr;
  logic [LOC_DWIDTH-1:0] ram_wr_data;
  logic                  ram_wr_src;

  modport master (
    output in_valid_a, in_addr_a, in_data_a,
    output in_valid_b, in_addr_b, in_data_b,
    input  in_ready_a, in_ready_b,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_wr_src
  );

  modport slave (
    input  in_valid_a, in_addr_a, in_data_a,
    input  in_valid_b, in_addr_b, in_data_b,
    output in_ready_a, in_ready_b,
    output ram_wr_en, ram_wr_addr, ram_wr_data, ram_wr_src
  );
endinterface

// File: rtl/dsel_req_fifo.sv
// Synchronous {addr, data} request FIFO; ready/full depends only on the registered count.
module dsel_req_fifo #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [DWIDTH-1:0] i_data,
  output logic [AWIDTH-1:0] o_addr,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
);

  logic [AWIDTH+DWIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic                     w_push_ok;
  logic                     w_pop_ok;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {i_addr, i_data};
  end

  assign {o_addr, o_data} = r_mem[r_rd_ptr];

endmodule

// File: rtl/dsel_wr_arbiter.sv
// Write-side arbiter: drains channel FIFOs A/B into the registered SRAM write port,
// fixed-priority or burst-limited round-robin.
//
// state | meaning
// IDLE  | nothing popped in the previous cycle
// GNT_A | channel A popped in the previous cycle
// GNT_B | channel B popped in the previous cycle
module dsel_wr_arbiter
  import dsel_arb_pkg::*;
#(
  parameter int LOC_AWIDTH = 32,
  parameter int LOC_DWIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dsel_wr_arbiter_if.slave bus,
  input  logic [31:0]      arb_cfg,
  output logic             arb_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BURST_MAX) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  arb_state_e            r_state;
  arb_state_e            w_next_state;
  logic [BW-1:0]         r_burst_cnt;
  logic [BW-1:0]         w_burst_nxt;
  logic                  r_last_src;

  logic                  r_wr_en;
  logic [LOC_AWIDTH-1:0] r_wr_addr;
  logic [LOC_DWIDTH-1:0] r_wr_data;
  logic                  r_wr_src;

  logic                  w_pop_a;
  logic                  w_pop_b;
  logic                  w_sel_src;
  logic [LOC_AWIDTH-1:0] w_sel_addr;
  logic [LOC_DWIDTH-1:0] w_sel_data;

  logic                  w_full_a, w_full_b;
  logic                  w_empty_a, w_empty_b;
  logic                  w_ne_a, w_ne_b;
  logic [CW-1:0]         w_cnt_a, w_cnt_b;
  logic [LOC_AWIDTH-1:0] w_head_addr_a, w_head_addr_b;
  logic [LOC_DWIDTH-1:0] w_head_data_a, w_head_data_b;
  logic                  w_mode_rr;
  logic                  w_prio_b;
  logic                  w_unused;

  assign w_mode_rr = arb_cfg[CFG_MODE_BIT];
  assign w_prio_b  = arb_cfg[CFG_PRIO_BIT];
  assign w_unused  = ^{arb_cfg[31:3], arb_cfg[1], w_cnt_a, w_cnt_b};
  assign w_ne_a    = !w_empty_a;
  assign w_ne_b    = !w_empty_b;

  dsel_req_fifo #(.AWIDTH(LOC_AWIDTH), .DWIDTH(LOC_DWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.in_valid_a),
    .i_pop   (w_pop_a),
    .i_addr  (bus.in_addr_a),
    .i_data  (bus.in_data_a),
    .o_addr  (w_head_addr_a),
    .o_data  (w_head_data_a),
    .o_full  (w_full_a),
    .o_empty (w_empty_a),
    .o_count (w_cnt_a)
  );

  dsel_req_fifo #(.AWIDTH(LOC_AWIDTH), .DWIDTH(LOC_DWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.in_valid_b),
    .i_pop   (w_pop_b),
    .i_addr  (bus.in_addr_b),
    .i_data  (bus.in_data_b),
    .o_addr  (w_head_addr_b),
    .o_data  (w_head_data_b),
    .o_full  (w_full_b),
    .o_empty (w_empty_b),
    .o_count (w_cnt_b)
  );

  assign bus.in_ready_a = !w_full_a;
  assign bus.in_ready_b = !w_full_b;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
      r_last_src  <= SRC_B;
    end else begin
      r_state     <= w_next_state;
      r_burst_cnt <= w_burst_nxt;
      if (w_next_state != IDLE) r_last_src <= src_of(w_next_state);
    end
  end

  // The grant chosen here is popped in this same cycle.
  always_comb begin
    w_next_state = IDLE;
    if (!w_mode_rr) begin
      if (w_prio_b) w_next_state = w_ne_b ? GNT_B : (w_ne_a ? GNT_A : IDLE);
      else          w_next_state = w_ne_a ? GNT_A : (w_ne_b ? GNT_B : IDLE);
    end else begin
      unique case (r_state)
        GNT_A: begin
          if (w_ne_a && (r_burst_cnt < BURST_LAST || !w_ne_b)) w_next_state = GNT_A;
          else if (w_ne_b)                                    w_next_state = GNT_B;
        end
        GNT_B: begin
          if (w_ne_b && (r_burst_cnt < BURST_LAST || !w_ne_a)) w_next_state = GNT_B;
          else if (w_ne_a)                                    w_next_state = GNT_A;
        end
        default: begin
          if (w_ne_a && w_ne_b) w_next_state = (r_last_src == SRC_B) ? GNT_A : GNT_B;
          else if (w_ne_a)      w_next_state = GNT_A;
          else if (w_ne_b)      w_next_state = GNT_B;
        end
      endcase
    end
  end

  // Fixed mode pins the counter at zero, so a mode change always starts a fresh burst.
  always_comb begin
    w_burst_nxt = '0;
    if (w_mode_rr && w_next_state != IDLE && w_next_state == r_state) begin
      w_burst_nxt = (r_burst_cnt < BURST_LAST) ? r_burst_cnt + BW'(1) : r_burst_cnt;
    end
  end

  always_comb begin
    w_pop_a    = (w_next_state == GNT_A);
    w_pop_b    = (w_next_state == GNT_B);
    w_sel_src  = w_pop_b ? SRC_B : SRC_A;
    w_sel_addr = w_pop_b ? w_head_addr_b : w_head_addr_a;
    w_sel_data = w_pop_b ? w_head_data_b : w_head_data_a;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_src  <= SRC_A;
    end else begin
      r_wr_en <= w_pop_a || w_pop_b;
      if (w_pop_a || w_pop_b) begin
        r_wr_addr <= w_sel_addr;
        r_wr_data <= w_sel_data;
        r_wr_src  <= w_sel_src;
      end
    end
  end

  assign bus.ram_wr_en   = r_wr_en;
  assign bus.ram_wr_addr = r_wr_addr;
  assign bus.ram_wr_data = r_wr_data;
  assign bus.ram_wr_src  = r_wr_src;
  assign arb_busy        = w_ne_a || w_ne_b || r_wr_en;

endmodule
